// File: rtl/time_set_ctrl_pkg.sv
// Shared mode encodings for the time-setting controller and the display mux.
package time_set_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_MIN = 2'd1,
        MODE_SET_HR  = 2'd2,
        MODE_SETTLE  = 2'd3
    } mode_e;

endpackage

// File: rtl/button_debounce.sv
// Raw button synchronizer plus debounce sampled on the set-rate tick.
// Emits the debounced level and a one-cycle pulse on its rising change.
module button_debounce #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_TICKS = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_raw,
    output logic stable,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];

    // Metastability chain for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], btn_raw};
    end

    // Accept a level change only after it persists for DEBOUNCE_TICKS tick samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (tick) begin
                if (synced != stable) begin
                    if (cnt == CNT_LAST) begin
                        stable <= synced;
                        cnt    <= '0;
                        press  <= synced;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set sequencer: forwards 1 Hz ticks in RUN, issues minute/hour
// increments with press-then-auto-repeat timing while a set button is held.
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_TICKS = 2,
    parameter int REPEAT_DELAY   = 3,
    parameter int RELEASE_TICKS  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_set,
    input  logic       btn_min,
    input  logic       btn_hr,
    output logic       inc_sec,
    output logic       inc_min,
    output logic       inc_hr,
    output logic       sec_clear,
    output logic [1:0] mode
);

    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam int SW = $clog2(RELEASE_TICKS + 1);
    localparam logic [RW-1:0] RPT_MAX     = RW'(REPEAT_DELAY);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(RELEASE_TICKS - 1);

    logic stable_min, press_min, stable_hr, press_hr;

    mode_e         state, state_n;
    logic [RW-1:0] rpt_cnt;
    logic [SW-1:0] settle_cnt;
    logic          held;
    logic          inc_sec_n, inc_min_n, inc_hr_n, sec_clear_n;
    logic          rpt_clr, settle_clr;

    button_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_min (
        .clk(clk), .rst_n(rst_n), .tick(tick_set), .btn_raw(btn_min),
        .stable(stable_min), .press(press_min)
    );

    button_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_hr (
        .clk(clk), .rst_n(rst_n), .tick(tick_set), .btn_raw(btn_hr),
        .stable(stable_hr), .press(press_hr)
    );

    assign mode = state;
    assign held = (state == MODE_SET_MIN) ? stable_min :
                  (state == MODE_SET_HR)  ? stable_hr  : 1'b0;

    // Next state and next-cycle pulse values; hours win on simultaneous presses.
    always_comb begin
        state_n     = state;
        inc_sec_n   = 1'b0;
        inc_min_n   = 1'b0;
        inc_hr_n    = 1'b0;
        sec_clear_n = 1'b0;
        rpt_clr     = 1'b0;
        settle_clr  = 1'b0;
        case (state)
            MODE_RUN: begin
                inc_sec_n = tick_1hz;
                if (press_hr) begin
                    state_n = MODE_SET_HR;  inc_hr_n = 1'b1;  sec_clear_n = 1'b1; rpt_clr = 1'b1;
                end else if (press_min) begin
                    state_n = MODE_SET_MIN; inc_min_n = 1'b1; sec_clear_n = 1'b1; rpt_clr = 1'b1;
                end
            end
            MODE_SET_MIN: begin
                if (press_hr || (!stable_min && stable_hr)) begin
                    state_n = MODE_SET_HR; inc_hr_n = 1'b1; rpt_clr = 1'b1;
                end else if (!stable_min) begin
                    state_n = MODE_SETTLE; settle_clr = 1'b1;
                end else if (tick_set && rpt_cnt == RPT_MAX) begin
                    inc_min_n = 1'b1;
                end
            end
            MODE_SET_HR: begin
                if (press_min || (!stable_hr && stable_min)) begin
                    state_n = MODE_SET_MIN; inc_min_n = 1'b1; rpt_clr = 1'b1;
                end else if (!stable_hr) begin
                    state_n = MODE_SETTLE; settle_clr = 1'b1;
                end else if (tick_set && rpt_cnt == RPT_MAX) begin
                    inc_hr_n = 1'b1;
                end
            end
            MODE_SETTLE: begin
                if (press_hr) begin
                    state_n = MODE_SET_HR;  inc_hr_n = 1'b1;  rpt_clr = 1'b1;
                end else if (press_min) begin
                    state_n = MODE_SET_MIN; inc_min_n = 1'b1; rpt_clr = 1'b1;
                end else if (tick_set && settle_cnt == SETTLE_LAST) begin
                    state_n = MODE_RUN;
                end
            end
            default: state_n = MODE_RUN;
        endcase
    end

    // State register and registered single-cycle output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MODE_RUN;
            inc_sec   <= 1'b0;
            inc_min   <= 1'b0;
            inc_hr    <= 1'b0;
            sec_clear <= 1'b0;
        end else begin
            state     <= state_n;
            inc_sec   <= inc_sec_n;
            inc_min   <= inc_min_n;
            inc_hr    <= inc_hr_n;
            sec_clear <= sec_clear_n;
        end
    end

    // Auto-repeat delay (saturating while held) and release timeout counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt    <= '0;
            settle_cnt <= '0;
        end else begin
            if (rpt_clr)
                rpt_cnt <= '0;
            else if (tick_set && held && rpt_cnt != RPT_MAX)
                rpt_cnt <= rpt_cnt + 1'b1;
            if (settle_clr)
                settle_cnt <= '0;
            else if (state == MODE_SETTLE && tick_set && settle_cnt != SETTLE_LAST)
                settle_cnt <= settle_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: run forwarding, set entry, auto-repeat,
// settle timeout, simultaneous/switch presses, glitch rejection, async reset.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0, tick_set = 1'b0, btn_min = 1'b0, btn_hr = 1'b0;
    logic       inc_sec, inc_min, inc_hr, sec_clear;
    logic [1:0] mode;

    int checks = 0, errors = 0;
    int n_sec = 0, n_min = 0, n_hr = 0, n_clr = 0, n_clr_min = 0, n_clr_hr = 0, n_both = 0;

    time_set_ctrl dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_set(tick_set),
        .btn_min(btn_min), .btn_hr(btn_hr), .inc_sec(inc_sec), .inc_min(inc_min),
        .inc_hr(inc_hr), .sec_clear(sec_clear), .mode(mode)
    );

    always #5 clk = ~clk;

    // Pulse tallies, sampled mid-cycle.
    always @(negedge clk) begin
        if (inc_sec)               n_sec++;
        if (inc_min)               n_min++;
        if (inc_hr)                n_hr++;
        if (sec_clear)             n_clr++;
        if (sec_clear && inc_min)  n_clr_min++;
        if (sec_clear && inc_hr)   n_clr_hr++;
        if (inc_min && inc_hr)     n_both++;
    end

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic pulse_set();
        @(negedge clk) tick_set = 1'b1;
        @(negedge clk) tick_set = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_1hz();
        @(negedge clk) tick_1hz = 1'b1;
        @(negedge clk) tick_1hz = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_sync();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_outs", int'({inc_sec, inc_min, inc_hr, sec_clear}), 0);
        chk("rst_mode", int'(mode), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: RUN forwards 1 Hz ticks with one cycle of latency
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) tick_1hz = 1'b1;
            @(negedge clk) tick_1hz = 1'b0;
            chk("sec_latency", int'(inc_sec), 1);
            @(negedge clk);
            chk("sec_width", int'(inc_sec), 0);
            repeat (2) @(negedge clk);
        end
        chk("run_sec_count", n_sec, 3);
        chk("run_mode", int'(mode), 0);

        // 2: btn_min debounced over two set ticks -> SET_MIN with clear + entry inc
        btn_min = 1'b1;
        wait_sync();
        pulse_set();
        chk("min_debounce_wait", int'(mode), 0);
        pulse_set();
        chk("set_min_mode", int'(mode), 1);
        chk("set_min_entry", n_min, 1);
        chk("set_min_clear", n_clr, 1);
        chk("clear_with_min", n_clr_min, 1);
        pulse_1hz();
        chk("set_sec_blocked", n_sec, 3);

        // 3: repeat counter saturates after 3 ticks, then one inc per tick
        repeat (4) pulse_set();
        chk("repeat_first", n_min, 2);
        repeat (2) pulse_set();
        chk("repeat_total", n_min, 4);
        chk("repeat_mode", int'(mode), 1);

        // 4: release -> incs continue until debounce drops, then SETTLE, then RUN
        btn_min = 1'b0;
        wait_sync();
        repeat (2) pulse_set();
        chk("release_incs", n_min, 6);
        chk("settle_mode", int'(mode), 3);
        repeat (4) pulse_set();
        chk("settle_hold", int'(mode), 3);
        pulse_set();
        chk("settle_to_run", int'(mode), 0);
        chk("settle_no_sec", n_sec, 3);
        pulse_1hz();
        chk("run_resume_sec", n_sec, 4);

        // 5: simultaneous press -> SET_HR; release hr with min held -> SET_MIN
        btn_min = 1'b1;
        btn_hr  = 1'b1;
        wait_sync();
        repeat (2) pulse_set();
        chk("both_mode", int'(mode), 2);
        chk("both_hr_inc", n_hr, 1);
        chk("both_no_min", n_min, 6);
        chk("both_clear", n_clr, 2);
        chk("clear_with_hr", n_clr_hr, 1);
        btn_hr = 1'b0;
        wait_sync();
        repeat (2) pulse_set();
        chk("switch_mode", int'(mode), 1);
        chk("switch_min_inc", n_min, 7);
        chk("switch_no_clear", n_clr, 2);

        // 6: one-tick glitch on btn_hr ignored; real press switches to SET_HR
        btn_hr = 1'b1;
        wait_sync();
        pulse_set();
        btn_hr = 1'b0;
        wait_sync();
        pulse_set();
        chk("glitch_mode", int'(mode), 1);
        chk("glitch_no_hr", n_hr, 1);
        btn_hr = 1'b1;
        wait_sync();
        repeat (2) pulse_set();
        chk("press_hr_mode", int'(mode), 2);
        chk("press_hr_inc", n_hr, 2);
        chk("press_hr_min_rpt", n_min, 8);
        chk("press_hr_no_clear", n_clr, 2);
        chk("never_both", n_both, 0);

        // Asynchronous reset mid SET_HR, checked before any clock edge
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mode", int'(mode), 0);
        chk("async_rst_outs", int'({inc_sec, inc_min, inc_hr, sec_clear}), 0);
        btn_min = 1'b0;
        btn_hr  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_mode", int'(mode), 0);
        chk("post_rst_no_pulse", n_min + n_hr, 10);
        pulse_1hz();
        chk("post_rst_sec", n_sec, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
